// File: rtl/lsc_uart_cmd_bridge_pkg.sv
// Shared constants for the UART command bridge: host protocol bytes,
// FSM state encoding and a saturating counter helper.
package lsc_uart_cmd_bridge_pkg;

    localparam logic [7:0] CMD_WR   = 8'h57;
    localparam logic [7:0] CMD_RD   = 8'h52;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_DATA = 8'h44;
    localparam logic [7:0] RSP_ERR  = 8'h45;

    localparam logic [2:0] ST_IDLE_ENC     = 3'd0;
    localparam logic [2:0] ST_GET_ADDR_ENC = 3'd1;
    localparam logic [2:0] ST_GET_DATA_ENC = 3'd2;
    localparam logic [2:0] ST_WRITE_ENC    = 3'd3;
    localparam logic [2:0] ST_READ_ENC     = 3'd4;
    localparam logic [2:0] ST_RD_WAIT_ENC  = 3'd5;
    localparam logic [2:0] ST_RESP_ENC     = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE     = ST_IDLE_ENC,
        ST_GET_ADDR = ST_GET_ADDR_ENC,
        ST_GET_DATA = ST_GET_DATA_ENC,
        ST_WRITE    = ST_WRITE_ENC,
        ST_READ     = ST_READ_ENC,
        ST_RD_WAIT  = ST_RD_WAIT_ENC,
        ST_RESP     = ST_RESP_ENC
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : (v + 8'd1);
    endfunction

endpackage

// File: rtl/lsc_uart_cmd_bridge.sv
// Byte-stream command parser: decodes 'W'/'R' host commands into single-cycle
// register strobes and returns 'K', 'D'+data or 'E' on the UART transmit side.
module lsc_uart_cmd_bridge
    import lsc_uart_cmd_bridge_pkg::*;
#(
    parameter logic [23:0] IDLE_TIMEOUT = 24'd1000000,
    parameter logic [7:0]  RD_TIMEOUT   = 8'd64
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    output logic [7:0] o_reg_addr,
    output logic [7:0] o_reg_wdata,
    output logic       o_reg_we,
    output logic       o_reg_re,
    input  logic [7:0] i_reg_rdata,
    input  logic       i_reg_rvalid,
    output logic       o_busy,
    output logic [7:0] o_err_cnt
);

    state_e      r_state;
    logic        r_is_rd;
    logic [7:0]  r_reg_addr;
    logic [7:0]  r_reg_wdata;
    logic        r_reg_we;
    logic        r_reg_re;
    logic [7:0]  r_tx_data;
    logic [7:0]  r_tx_next;
    logic        r_tx_left;
    logic        r_rd_hit;
    logic [23:0] r_to_cnt;
    logic [7:0]  r_rd_cnt;
    logic [7:0]  r_err_cnt;
    logic        r_busy;

    state_e      w_state_nxt;
    logic        w_is_rd_nxt;
    logic [7:0]  w_addr_nxt;
    logic [7:0]  w_wdata_nxt;
    logic [7:0]  w_tx_data_nxt;
    logic [7:0]  w_tx_next_nxt;
    logic        w_tx_left_nxt;
    logic        w_rd_hit_nxt;
    logic [23:0] w_to_cnt_nxt;
    logic [7:0]  w_rd_cnt_nxt;
    logic        w_err;
    logic        w_drop;

    // Next-state, buffer and counter logic; errors of one cycle collapse into a single increment
    always_comb begin
        w_state_nxt   = r_state;
        w_is_rd_nxt   = r_is_rd;
        w_addr_nxt    = r_reg_addr;
        w_wdata_nxt   = r_reg_wdata;
        w_tx_data_nxt = r_tx_data;
        w_tx_next_nxt = r_tx_next;
        w_tx_left_nxt = r_tx_left;
        w_rd_hit_nxt  = r_rd_hit;
        w_to_cnt_nxt  = r_to_cnt;
        w_rd_cnt_nxt  = r_rd_cnt;
        w_err         = 1'b0;
        w_drop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_to_cnt_nxt = 24'd0;
                if (i_rx_valid) begin
                    if ((i_rx_data == CMD_WR) || (i_rx_data == CMD_RD)) begin
                        w_is_rd_nxt = (i_rx_data == CMD_RD);
                        w_state_nxt = ST_GET_ADDR;
                    end else begin
                        w_tx_data_nxt = RSP_ERR;
                        w_tx_left_nxt = 1'b0;
                        w_err         = 1'b1;
                        w_state_nxt   = ST_RESP;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GET_ADDR: begin
                if (i_rx_valid) begin
                    w_addr_nxt   = i_rx_data;
                    w_to_cnt_nxt = 24'd0;
                    w_state_nxt  = r_is_rd ? ST_READ : ST_GET_DATA;
                end else if (r_to_cnt == (IDLE_TIMEOUT - 24'd1)) begin
                    w_err        = 1'b1;
                    w_to_cnt_nxt = 24'd0;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 24'd1;
                end
            end
            ST_GET_DATA: begin
                if (i_rx_valid) begin
                    w_wdata_nxt  = i_rx_data;
                    w_to_cnt_nxt = 24'd0;
                    w_state_nxt  = ST_WRITE;
                end else if (r_to_cnt == (IDLE_TIMEOUT - 24'd1)) begin
                    w_err        = 1'b1;
                    w_to_cnt_nxt = 24'd0;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 24'd1;
                end
            end
            ST_WRITE: begin
                w_drop        = i_rx_valid;
                w_tx_data_nxt = RSP_OK;
                w_tx_left_nxt = 1'b0;
                w_state_nxt   = ST_RESP;
            end
            ST_READ: begin
                // Read data may already be returned alongside the strobe itself.
                w_drop       = i_rx_valid;
                w_rd_cnt_nxt = 8'd1;
                w_rd_hit_nxt = i_reg_rvalid;
                if (i_reg_rvalid) begin
                    w_tx_data_nxt = RSP_DATA;
                    w_tx_next_nxt = i_reg_rdata;
                    w_tx_left_nxt = 1'b1;
                end else begin
                    w_tx_left_nxt = r_tx_left;
                end
                w_state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                w_drop = i_rx_valid;
                if (r_rd_hit) begin
                    w_state_nxt = ST_RESP;
                end else if (i_reg_rvalid) begin
                    w_tx_data_nxt = RSP_DATA;
                    w_tx_next_nxt = i_reg_rdata;
                    w_tx_left_nxt = 1'b1;
                    w_state_nxt   = ST_RESP;
                end else if (r_rd_cnt >= RD_TIMEOUT) begin
                    w_tx_data_nxt = RSP_ERR;
                    w_tx_left_nxt = 1'b0;
                    w_err         = 1'b1;
                    w_state_nxt   = ST_RESP;
                end else begin
                    w_rd_cnt_nxt = r_rd_cnt + 8'd1;
                end
            end
            ST_RESP: begin
                w_drop = i_rx_valid;
                if (i_tx_ready) begin
                    if (r_tx_left) begin
                        w_tx_data_nxt = r_tx_next;
                        w_tx_left_nxt = 1'b0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_is_rd     <= 1'b0;
            r_reg_addr  <= 8'd0;
            r_reg_wdata <= 8'd0;
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_tx_data   <= 8'd0;
            r_tx_next   <= 8'd0;
            r_tx_left   <= 1'b0;
            r_rd_hit    <= 1'b0;
            r_to_cnt    <= 24'd0;
            r_rd_cnt    <= 8'd0;
            r_err_cnt   <= 8'd0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_is_rd     <= w_is_rd_nxt;
            r_reg_addr  <= w_addr_nxt;
            r_reg_wdata <= w_wdata_nxt;
            r_reg_we    <= (w_state_nxt == ST_WRITE);
            r_reg_re    <= (w_state_nxt == ST_READ);
            r_tx_data   <= w_tx_data_nxt;
            r_tx_next   <= w_tx_next_nxt;
            r_tx_left   <= w_tx_left_nxt;
            r_rd_hit    <= w_rd_hit_nxt;
            r_to_cnt    <= w_to_cnt_nxt;
            r_rd_cnt    <= w_rd_cnt_nxt;
            r_err_cnt   <= (w_err || w_drop) ? sat_inc8(r_err_cnt) : r_err_cnt;
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    // The transmit strobe must coincide with the cycle the UART can take the byte.
    assign o_tx_valid  = (r_state == ST_RESP) && i_tx_ready;
    assign o_tx_data   = r_tx_data;
    assign o_reg_addr  = r_reg_addr;
    assign o_reg_wdata = r_reg_wdata;
    assign o_reg_we    = r_reg_we;
    assign o_reg_re    = r_reg_re;
    assign o_busy      = r_busy;
    assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_lsc_uart_cmd_bridge.sv
// Self-checking bench for lsc_uart_cmd_bridge: table of directed commands,
// randomized commands against a transaction-level model, and corner sequences.
module tb_lsc_uart_cmd_bridge;

    logic       clk;
    logic       resetn;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       i_tx_ready;
    logic [7:0] o_reg_addr;
    logic [7:0] o_reg_wdata;
    logic       o_reg_we;
    logic       o_reg_re;
    logic [7:0] i_reg_rdata;
    logic       i_reg_rvalid;
    logic       o_busy;
    logic [7:0] o_err_cnt;

    lsc_uart_cmd_bridge #(
        .IDLE_TIMEOUT(24'd100),
        .RD_TIMEOUT  (8'd64)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .i_rx_data   (i_rx_data),
        .i_rx_valid  (i_rx_valid),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .i_tx_ready  (i_tx_ready),
        .o_reg_addr  (o_reg_addr),
        .o_reg_wdata (o_reg_wdata),
        .o_reg_we    (o_reg_we),
        .o_reg_re    (o_reg_re),
        .i_reg_rdata (i_reg_rdata),
        .i_reg_rvalid(i_reg_rvalid),
        .o_busy      (o_busy),
        .o_err_cnt   (o_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int err_model = 0;
    int bp_mode = 0;

    logic [15:0] q_wr[$];
    logic [7:0]  q_rd[$];
    logic [7:0]  q_tx[$];

    typedef struct {
        logic [7:0] b0, b1, b2;
        int nb;
        int dly;
        logic [7:0] rdata;
        int nwr;
        int nrd;
        int ntx;
        logic [7:0] tx0, tx1;
        int erri;
    } vec_t;
    vec_t tbl[8];

    // Transmit-ready driver, updated just after the rising edge
    initial begin
        i_tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (bp_mode == 0) i_tx_ready = 1'b1;
            else if (bp_mode == 1) i_tx_ready = 1'($urandom_range(0, 1));
            else i_tx_ready = 1'b0;
        end
    end

    // Bus monitor sampling on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (o_reg_we) q_wr.push_back({o_reg_addr, o_reg_wdata});
                if (o_reg_re) q_rd.push_back(o_reg_addr);
                if (o_tx_valid) q_tx.push_back(o_tx_data);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_q();
        q_wr.delete();
        q_rd.delete();
        q_tx.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (o_busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (o_busy) chk({name, " idle_timeout"}, 32'(o_busy), 32'd0);
        @(negedge clk);
    endtask

    // Returns read data dly cycles after the read strobe (0 = same cycle)
    task automatic respond(input string name, input int dly, input logic [7:0] rdata);
        int k = 0;
        while (!o_reg_re && k < 8) begin
            @(negedge clk);
            k++;
        end
        if (!o_reg_re) chk({name, " no_re"}, 32'(o_reg_re), 32'd1);
        repeat (dly) @(negedge clk);
        i_reg_rdata  = rdata;
        i_reg_rvalid = 1'b1;
        @(negedge clk);
        i_reg_rvalid = 1'b0;
    endtask

    task automatic check_after(input string name, input int nwr, input logic [7:0] wa,
                               input logic [7:0] wd, input int nrd, input logic [7:0] ra,
                               input int ntx, input logic [7:0] tx0, input logic [7:0] tx1);
        chk({name, " n_we"}, 32'(q_wr.size()), 32'(nwr));
        if (nwr == 1 && q_wr.size() == 1) chk({name, " wr_addr_data"}, 32'(q_wr[0]), 32'({wa, wd}));
        chk({name, " n_re"}, 32'(q_rd.size()), 32'(nrd));
        if (nrd == 1 && q_rd.size() == 1) chk({name, " rd_addr"}, 32'(q_rd[0]), 32'(ra));
        chk({name, " n_tx"}, 32'(q_tx.size()), 32'(ntx));
        if (ntx >= 1 && q_tx.size() >= 1) chk({name, " tx0"}, 32'(q_tx[0]), 32'(tx0));
        if (ntx == 2 && q_tx.size() >= 2) chk({name, " tx1"}, 32'(q_tx[1]), 32'(tx1));
        chk({name, " err_cnt"}, 32'(o_err_cnt), 32'(err_model));
    endtask

    task automatic run_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input int nb, input int dly, input logic [7:0] rdata);
        clear_q();
        send_byte(b0);
        if (nb >= 2) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(b1);
        end
        if (nb == 3) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(b2);
        end
        if (b0 == 8'h52 && dly >= 0) respond("cmd", dly, rdata);
        wait_idle("cmd", 600);
    endtask

    function automatic void bump_err(input int inc);
        err_model = (err_model + inc > 255) ? 255 : err_model + inc;
    endfunction

    initial begin
        logic [7:0] op, a, d, rd;
        int dly;
        int nwr, nrd, ntx, inc;
        logic [7:0] t0, t1;

        tbl[0] = '{8'h57, 8'h10, 8'hA5, 3, -1, 8'h00, 1, 0, 1, 8'h4B, 8'h00, 0};
        tbl[1] = '{8'h52, 8'h22, 8'h00, 2,  3, 8'h5C, 0, 1, 2, 8'h44, 8'h5C, 0};
        tbl[2] = '{8'h41, 8'h00, 8'h00, 1, -1, 8'h00, 0, 0, 1, 8'h45, 8'h00, 1};
        tbl[3] = '{8'h52, 8'h33, 8'h00, 2, -1, 8'h00, 0, 1, 1, 8'h45, 8'h00, 1};
        tbl[4] = '{8'h52, 8'h44, 8'h00, 2,  0, 8'h99, 0, 1, 2, 8'h44, 8'h99, 0};
        tbl[5] = '{8'h57, 8'hFF, 8'h00, 3, -1, 8'h00, 1, 0, 1, 8'h4B, 8'h00, 0};
        tbl[6] = '{8'h52, 8'h01, 8'h00, 2, 63, 8'h3C, 0, 1, 2, 8'h44, 8'h3C, 0};
        tbl[7] = '{8'h00, 8'h00, 8'h00, 1, -1, 8'h00, 0, 0, 1, 8'h45, 8'h00, 1};

        resetn = 1'b0;
        i_rx_data = 8'h00;
        i_rx_valid = 1'b0;
        i_reg_rdata = 8'h00;
        i_reg_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset tx_valid", 32'(o_tx_valid), 32'd0);
        chk("reset tx_data", 32'(o_tx_data), 32'd0);
        chk("reset addr", 32'(o_reg_addr), 32'd0);
        chk("reset wdata", 32'(o_reg_wdata), 32'd0);
        chk("reset we_re", 32'({o_reg_we, o_reg_re}), 32'd0);
        chk("reset busy", 32'(o_busy), 32'd0);
        chk("reset err", 32'(o_err_cnt), 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_cmd(tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].nb, tbl[i].dly, tbl[i].rdata);
            bump_err(tbl[i].erri);
            check_after($sformatf("tbl%0d", i), tbl[i].nwr, tbl[i].b1, tbl[i].b2,
                        tbl[i].nrd, tbl[i].b1, tbl[i].ntx, tbl[i].tx0, tbl[i].tx1);
        end

        // Interbyte timeout: partial 'W' then silence
        clear_q();
        send_byte(8'h57);
        send_byte(8'h10);
        repeat (95) @(negedge clk);
        chk("timeout not_early busy", 32'(o_busy), 32'd1);
        repeat (6) @(negedge clk);
        bump_err(1);
        chk("timeout busy", 32'(o_busy), 32'd0);
        check_after("timeout", 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00);

        // Long but legal gap keeps the command alive
        clear_q();
        send_byte(8'h57);
        send_byte(8'h20);
        repeat (60) @(negedge clk);
        send_byte(8'h5A);
        wait_idle("gap60", 100);
        check_after("gap60", 1, 8'h20, 8'h5A, 0, 8'h00, 1, 8'h4B, 8'h00);
        run_cmd(8'h57, 8'h11, 8'h22, 3, -1, 8'h00);
        check_after("post_timeout_wr", 1, 8'h11, 8'h22, 0, 8'h00, 1, 8'h4B, 8'h00);

        // Backpressure during a read response plus a dropped byte
        clear_q();
        bp_mode = 2;
        send_byte(8'h52);
        send_byte(8'h22);
        respond("bp", 2, 8'h5C);
        repeat (3) @(negedge clk);
        send_byte(8'h57);
        bump_err(1);
        repeat (18) @(negedge clk);
        chk("bp stalled n_tx", 32'(q_tx.size()), 32'd0);
        chk("bp held data", 32'(o_tx_data), 32'h44);
        chk("bp busy", 32'(o_busy), 32'd1);
        bp_mode = 0;
        wait_idle("bp", 50);
        check_after("bp", 0, 8'h00, 8'h00, 1, 8'h22, 2, 8'h44, 8'h5C);
        repeat (3) @(negedge clk);
        chk("drop not_queued busy", 32'(o_busy), 32'd0);

        // Randomized commands with random backpressure
        bp_mode = 1;
        for (int i = 0; i < 40; i++) begin
            int sel = $urandom_range(0, 9);
            a = 8'($urandom);
            d = 8'($urandom);
            rd = 8'($urandom);
            dly = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 20);
            nwr = 0; nrd = 0; inc = 0; t1 = 8'h00;
            if (sel < 4) begin
                op = 8'h57; nwr = 1; ntx = 1; t0 = 8'h4B;
                run_cmd(op, a, d, 3, -1, rd);
            end else if (sel < 8) begin
                op = 8'h52; nrd = 1;
                if (dly < 0) begin ntx = 1; t0 = 8'h45; inc = 1; end
                else begin ntx = 2; t0 = 8'h44; t1 = rd; end
                run_cmd(op, a, d, 2, dly, rd);
            end else begin
                op = 8'($urandom);
                if (op == 8'h57 || op == 8'h52) op = 8'hA0;
                ntx = 1; t0 = 8'h45; inc = 1;
                run_cmd(op, a, d, 1, -1, rd);
            end
            bump_err(inc);
            check_after($sformatf("rnd%0d op%0h", i, op), nwr, a, d, nrd, a, ntx, t0, t1);
        end
        bp_mode = 0;

        // Saturation of the error counter
        while (err_model < 258) begin
            clear_q();
            send_byte(8'h41);
            wait_idle("sat", 20);
            err_model++;
        end
        err_model = 255;
        chk("saturate err", 32'(o_err_cnt), 32'hFF);

        // Reset while waiting for read data
        clear_q();
        send_byte(8'h52);
        send_byte(8'h77);
        repeat (10) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("rst_mid busy", 32'(o_busy), 32'd0);
        chk("rst_mid addr", 32'(o_reg_addr), 32'd0);
        chk("rst_mid err", 32'(o_err_cnt), 32'd0);
        chk("rst_mid strobes", 32'({o_reg_we, o_reg_re, o_tx_valid}), 32'd0);
        chk("rst_mid tx_data", 32'(o_tx_data), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        err_model = 0;
        repeat (2) @(negedge clk);
        run_cmd(8'h57, 8'h5A, 8'hC3, 3, -1, 8'h00);
        check_after("post_reset_wr", 1, 8'h5A, 8'hC3, 0, 8'h00, 1, 8'h4B, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
